// File: rtl/pc_gen_pkg.sv
// pc_gen shared types: fetch FSM states and the alignment-mask helper.
// Optional feature macro used by pc_gen: PC_MISALIGN_TRAP_EN.
package pc_pkg;

    typedef enum logic {
        PC_IDLE = 1'b0,
        PC_RUN  = 1'b1
    } pc_state_e;

    // Low-bit mask of an instruction slot (INSTR_BYTES is a power of two).
    function automatic int unsigned align_mask(input int unsigned bytes);
        return bytes - 1;
    endfunction

endpackage

// File: rtl/pc_gen_redirect_buf.sv
// One-entry redirect holding buffer for pc_gen.
// Keeps a redirect that arrives while fetch cannot advance.
module pc_redirect_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            set_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            consume_i,
    input  logic            clear_i,
    output logic            pending_o,
    output logic [XLEN-1:0] target_o
);

    logic            pend_q;
    logic [XLEN-1:0] tgt_q;

    // Clear beats set (latest target wins); consume drops a used entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else if (clear_i) begin
            pend_q <= 1'b0;
        end else if (set_i) begin
            pend_q <= 1'b1;
            tgt_q  <= target_i;
        end else if (consume_i) begin
            pend_q <= 1'b0;
        end
    end

    assign pending_o = pend_q;
    assign target_o  = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with stall-safe redirects.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     INSTR_BYTES = 4,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic            pcwrite_i,
    input  logic            fetch_ready_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] badaddr_o
);

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(align_mask(INSTR_BYTES));
    localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic            running;
    logic            advance;
    logic            pend;
    logic [XLEN-1:0] pend_tgt;
    logic            use_tgt;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_d;
`ifdef PC_MISALIGN_TRAP_EN
    logic            trap_d;
    logic            misalign_q;
    logic [XLEN-1:0] badaddr_q;
`endif

    // Advance qualifier and next-PC selection: flush, then pending, then +step.
    always_comb begin
        running = (state_q == PC_RUN);
        advance = running & start_i & ~stall_i & pcwrite_i & fetch_ready_i;
        use_tgt = flush_i | pend;
        tgt     = flush_i ? flush_pc_i : pend_tgt;
        pc_d    = pc_q + STEP;
`ifdef PC_MISALIGN_TRAP_EN
        trap_d  = 1'b0;
        if (use_tgt) begin
            if ((tgt & LOW_MASK) != '0) begin
                trap_d = 1'b1;
                pc_d   = TRAP_VEC;
            end else begin
                pc_d   = tgt;
            end
        end
`else
        if (use_tgt) begin
            pc_d = tgt & ~LOW_MASK;
        end
`endif
    end

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (running & start_i & flush_i & ~advance),
        .target_i  (flush_pc_i),
        .consume_i (advance),
        .clear_i   (~running | ~start_i),
        .pending_o (pend),
        .target_o  (pend_tgt)
    );

    // Fetch FSM with registered PC, valid and trap outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PC_IDLE;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            badaddr_q  <= '0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
            unique case (state_q)
                PC_IDLE: begin
                    pc_q    <= RESET_VEC;
                    valid_q <= start_i;
                    if (start_i) begin
                        state_q <= PC_RUN;
                    end
                end
                PC_RUN: begin
                    if (!start_i) begin
                        state_q <= PC_IDLE;
                        pc_q    <= RESET_VEC;
                        valid_q <= 1'b0;
                    end else if (advance) begin
                        pc_q <= pc_d;
`ifdef PC_MISALIGN_TRAP_EN
                        if (trap_d) begin
                            misalign_q <= 1'b1;
                            badaddr_q  <= tgt;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= PC_IDLE;
                    pc_q    <= RESET_VEC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
    assign badaddr_o  = badaddr_q;
`else
    assign misalign_o = 1'b0;
    assign badaddr_o  = '0;
`endif

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the pipelined CPU's IF stage, replacing the fixed 32-bit PC register. Holds the fetch PC and advances it sequentially. Accepts branch/jump redirects from EX, honours hazard-unit and memory stalls, and latches a redirect that arrives during a stall so it is not lost. Drives the instruction-memory address and a fetch-valid qualifier.

## Interface
Parameters:
- XLEN, 32: PC width in bits.
- INSTR_BYTES, 4: sequential increment; must be a power of two.
- RESET_VEC, 0: PC value after reset and while not started.
- TRAP_VEC, 32'h0000_0100: misaligned-redirect target (used only with the trap feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  one clock; reset is asynchronous and active-high.
- start_i  in  1  CPU run enable; low forces idle.
- stall_i  in  1  global stall (data-memory/cache).
- pcwrite_i  in  1  hazard-unit PC write enable; low holds PC.
- fetch_ready_i  in  1  instruction memory accepts the current pc_o.
- flush_i  in  1  redirect request from EX (taken branch/jump).
- flush_pc_i  in  XLEN  redirect target.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o is a live fetch address.
- misalign_o  out  1  one-cycle pulse on trapped redirect.
- badaddr_o  out  XLEN  last trapped redirect target.

## Operation
- Uses 2 registered states, IDLE and RUN; pending redirect is a separate flag plus an XLEN target register.
- IDLE: pc_o = RESET_VEC, pc_valid_o = 0, pending cleared. Goes to RUN on the edge where start_i = 1.
- RUN: pc_valid_o = 1. If start_i = 0, goes to IDLE next edge: pc_o = RESET_VEC and pending is cleared.
- advance = RUN & start_i & ~stall_i & pcwrite_i & fetch_ready_i.
- Next-PC priority on advance:
  - flush_i: flush_pc_i.
  - else pending: pending target; clears pending.
  - else pc_o + INSTR_BYTES.
- flush_i without advance (in RUN): target stored in pending; a later flush overwrites it (latest wins).
- flush_i together with pending on an advance edge: flush_pc_i wins, pending clears.
- Sequential add wraps modulo 2^XLEN; carry is discarded.
- flush_i in IDLE is ignored.

## Timing
- All outputs are registered. Reset values: pc_o = RESET_VEC, pc_valid_o = 0, misalign_o = 0, badaddr_o = 0, pending = 0, state = IDLE.
- Redirect latency: pc_o shows the target on the first advance edge at or after flush_i, exactly 1 cycle if not stalled.
- No advance: pc_o holds its value.
- rst_i mid-operation: immediate asynchronous return to reset values; pending is discarded.
- First fetch after start: RESET_VEC is valid the cycle after RUN is entered. The first advance yields RESET_VEC + INSTR_BYTES.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - A redirect target (flush or pending) with low log2(INSTR_BYTES) bits nonzero, when applied, loads TRAP_VEC instead.
  - misalign_o pulses for exactly 1 cycle on that edge.
  - badaddr_o captures the offending target.
- PC_MISALIGN_TRAP_EN undefined: the low bits of the target are forced to zero on load; misalign_o and badaddr_o are tied to 0.

## Structure
- Package pc_pkg holds the state enum (PC_IDLE, PC_RUN) and a localparam function for the alignment mask derived from INSTR_BYTES.
- One sub-module, pc_redirect_buf: pending flag plus target register with set/overwrite/consume/clear controls.
- Next-PC mux and state register live in the top.

## Test plan
- Reset then start_i = 1, all enables high, fetch_ready_i = 1: pc_o = 0, 4, 8, 12 on successive cycles; pc_valid_o rises 1 cycle after start.
- Branch: flush_i = 1 with flush_pc_i = 0x40 while PC = 0x10 and no stall: next pc_o = 0x40, then 0x44.
- Stalled redirect: stall_i = 1 for 3 cycles, flush_i to 0x80 in the first cycle, then to 0x90 in the second. PC holds throughout; after release pc_o = 0x90.
- Wrap: XLEN = 32, PC = 0xFFFF_FFFC, advance: pc_o = 0x0000_0000.
- start_i dropped with pending set: pc_o = RESET_VEC, pc_valid_o = 0. Restart gives a sequential fetch from RESET_VEC, with no stale redirect.
- Misaligned flush to 0x42:
  - Macro defined: pc_o = TRAP_VEC, misalign_o high for 1 cycle, badaddr_o = 0x42.
  - Macro undefined: pc_o = 0x40.
